// File: rtl/mcpu_avl_mem_model.sv
// Cycle-level Avalon-MM memory controller model behind the LTC: burst reads/writes
// into a 128-bit array with fixed read latency and command backpressure.
module mcpu_avl_mem_model #(
    parameter int    MEM_AW    = 12,
    parameter int    READ_LAT  = 4,
    parameter string INIT_FILE = ""
) (
    input  logic         clkrst_core_clk,
    input  logic         clkrst_core_rst,
    input  logic [24:0]  ltc2mc_avl_addr_0,
    input  logic [15:0]  ltc2mc_avl_be_0,
    input  logic         ltc2mc_avl_burstbegin_0,
    input  logic         ltc2mc_avl_read_req_0,
    input  logic         ltc2mc_avl_write_req_0,
    input  logic [4:0]   ltc2mc_avl_size_0,
    input  logic [127:0] ltc2mc_avl_wdata_0,
    output logic         ltc2mc_avl_ready_0,
    output logic [127:0] ltc2mc_avl_rdata_0,
    output logic         ltc2mc_avl_rdata_valid_0,
    output logic         err
);

    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RD_DATA} state_t;

    logic [127:0] mem [DEPTH];

    state_t            state, state_nxt;
    logic              live;
    logic [MEM_AW-1:0] base, base_nxt;
    logic [4:0]        len, len_nxt, idx, idx_nxt;
    logic [3:0]        lat, lat_nxt;
    logic              err_nxt;
    logic              we;
    logic [MEM_AW-1:0] waddr, raddr;
    logic [4:0]        size_len;
    logic              unused_addr;

    assign size_len    = (ltc2mc_avl_size_0 == 5'd0) ? 5'd1 : ltc2mc_avl_size_0;
    assign raddr       = base + MEM_AW'(idx);
    assign unused_addr = ^ltc2mc_avl_addr_0;

    // Held low through the drain beat so ready rises the cycle after the last rdata.
    assign ltc2mc_avl_ready_0 = live && (state == IDLE || state == WRITE) &&
                                !ltc2mc_avl_rdata_valid_0;

    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        len_nxt   = len;
        idx_nxt   = idx;
        lat_nxt   = lat;
        err_nxt   = err;
        we        = 1'b0;
        waddr     = raddr;
        case (state)
            IDLE: begin
                if (ltc2mc_avl_ready_0 && ltc2mc_avl_write_req_0) begin
                    base_nxt = ltc2mc_avl_addr_0[MEM_AW-1:0];
                    len_nxt  = size_len;
                    idx_nxt  = 5'd1;
                    we       = 1'b1;
                    waddr    = ltc2mc_avl_addr_0[MEM_AW-1:0];
                    if (size_len != 5'd1) state_nxt = WRITE;
                    if (ltc2mc_avl_read_req_0) err_nxt = 1'b1;
                end else if (ltc2mc_avl_ready_0 && ltc2mc_avl_read_req_0) begin
                    base_nxt  = ltc2mc_avl_addr_0[MEM_AW-1:0];
                    len_nxt   = size_len;
                    idx_nxt   = 5'd0;
                    lat_nxt   = 4'(READ_LAT - 1);
                    state_nxt = (READ_LAT == 1) ? RD_DATA : RD_WAIT;
                end
            end
            WRITE: begin
                if (ltc2mc_avl_write_req_0) begin
                    we = 1'b1;
                    if (idx == len - 5'd1) state_nxt = IDLE;
                    else                   idx_nxt   = idx + 5'd1;
                end
                if (ltc2mc_avl_read_req_0 || ltc2mc_avl_burstbegin_0) err_nxt = 1'b1;
            end
            RD_WAIT: begin
                // Leave one cycle early: the registered rdata stage adds the last one.
                if (lat <= 4'd1) state_nxt = RD_DATA;
                else             lat_nxt   = lat - 4'd1;
            end
            RD_DATA: begin
                if (idx == len - 5'd1) state_nxt = IDLE;
                else                   idx_nxt   = idx + 5'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state                    <= IDLE;
            live                     <= 1'b0;
            base                     <= '0;
            len                      <= '0;
            idx                      <= '0;
            lat                      <= '0;
            err                      <= 1'b0;
            ltc2mc_avl_rdata_0       <= '0;
            ltc2mc_avl_rdata_valid_0 <= 1'b0;
        end else begin
            state                    <= state_nxt;
            live                     <= 1'b1;
            base                     <= base_nxt;
            len                      <= len_nxt;
            idx                      <= idx_nxt;
            lat                      <= lat_nxt;
            err                      <= err_nxt;
            ltc2mc_avl_rdata_valid_0 <= (state == RD_DATA);
            if (state == RD_DATA) ltc2mc_avl_rdata_0 <= mem[raddr];
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (we) begin
            for (int i = 0; i < 16; i++) begin
                if (ltc2mc_avl_be_0[i]) mem[waddr][8*i +: 8] <= ltc2mc_avl_wdata_0[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mcpu_avl_mem_model.sv
// Directed bench for mcpu_avl_mem_model: stimulus pushes expected read beats
// (data + arrival cycle) into a queue; a negedge monitor pops and compares.
module tb_mcpu_avl_mem_model;

    localparam int MEM_AW   = 12;
    localparam int READ_LAT = 4;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [24:0]  addr = '0;
    logic [15:0]  be = '0;
    logic         burstbegin = 1'b0;
    logic         read_req = 1'b0;
    logic         write_req = 1'b0;
    logic [4:0]   size = '0;
    logic [127:0] wdata = '0;
    logic         ready;
    logic [127:0] rdata;
    logic         rdata_valid;
    logic         err;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    beat_t sb [$];

    mcpu_avl_mem_model #(.MEM_AW(MEM_AW), .READ_LAT(READ_LAT), .INIT_FILE("")) dut (
        .clkrst_core_clk          (clk),
        .clkrst_core_rst          (rst),
        .ltc2mc_avl_addr_0        (addr),
        .ltc2mc_avl_be_0          (be),
        .ltc2mc_avl_burstbegin_0  (burstbegin),
        .ltc2mc_avl_read_req_0    (read_req),
        .ltc2mc_avl_write_req_0   (write_req),
        .ltc2mc_avl_size_0        (size),
        .ltc2mc_avl_wdata_0       (wdata),
        .ltc2mc_avl_ready_0       (ready),
        .ltc2mc_avl_rdata_0       (rdata),
        .ltc2mc_avl_rdata_valid_0 (rdata_valid),
        .err                      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid beat must match the oldest expected beat, data and cycle.
    always @(negedge clk) begin
        if (!rst && rdata_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rdata_valid", 128'd1, 128'd0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("rdata", rdata, e.data);
                chk("rdata_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) chk("ready_timeout", 128'(ready), 128'd1);
    endtask

    // Beat k carries incr ? base_data+k : base_data. with_rd raises read_req on beat 0.
    task automatic write_burst(input logic [24:0] a, input logic [4:0] sz, input logic [15:0] b,
                               input logic [127:0] d, input bit incr, input bit with_rd);
        int nb;
        nb = (sz == 0) ? 1 : int'(sz);
        wait_ready();
        for (int k = 0; k < nb; k++) begin
            addr       = a;
            size       = sz;
            be         = b;
            wdata      = incr ? d + 128'(k) : d;
            burstbegin = (k == 0);
            read_req   = with_rd && (k == 0);
            write_req  = 1'b1;
            @(posedge clk); #1;
        end
        write_req  = 1'b0;
        read_req   = 1'b0;
        burstbegin = 1'b0;
    endtask

    task automatic read_burst(input logic [24:0] a, input logic [4:0] sz, input logic [127:0] e0,
                              input logic [127:0] e1, input logic [127:0] e2, input logic [127:0] e3);
        int nb;
        int c0;
        bit seen_high;
        logic [127:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        nb = (sz == 0) ? 1 : int'(sz);
        wait_ready();
        addr     = a;
        size     = sz;
        read_req = 1'b1;
        @(posedge clk); #1;
        c0       = cyc;
        read_req = 1'b0;
        for (int k = 0; k < nb; k++) sb.push_back('{data: ev[k], cyc: c0 + READ_LAT + k});
        seen_high = 1'b0;
        for (int i = 0; i < READ_LAT + nb; i++) begin
            @(negedge clk);
            if (ready) seen_high = 1'b1;
        end
        chk("ready_low_during_read", 128'(seen_high), 128'd0);
        @(negedge clk);
        chk("ready_after_read", 128'(ready), 128'd1);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", 128'(ready), 128'd0);
        chk("reset_rdata_valid", 128'(rdata_valid), 128'd0);
        chk("reset_err", 128'(err), 128'd0);
        chk("reset_rdata", rdata, 128'd0);
        rst = 1'b0;
        #1;
        chk("ready_before_first_clk", 128'(ready), 128'd0);
        @(negedge clk);
        chk("ready_after_release", 128'(ready), 128'd1);

        // Single beat write then read.
        write_burst(25'h10, 5'd1, 16'hFFFF, {16{8'hA5}}, 1'b0, 1'b0);
        read_burst(25'h10, 5'd1, {16{8'hA5}}, '0, '0, '0);

        // Four-beat burst, data = beat index.
        write_burst(25'h20, 5'd4, 16'hFFFF, 128'd0, 1'b1, 1'b0);
        read_burst(25'h20, 5'd4, 128'd0, 128'd1, 128'd2, 128'd3);

        // Partial byte-enable write over a zeroed word.
        write_burst(25'h30, 5'd1, 16'hFFFF, 128'd0, 1'b0, 1'b0);
        write_burst(25'h30, 5'd1, 16'h000F, {128{1'b1}}, 1'b0, 1'b0);
        read_burst(25'h30, 5'd1, 128'hFFFF_FFFF, '0, '0, '0);

        // Burst wrapping past the top of the array.
        write_burst(25'hFFF, 5'd3, 16'hFFFF, 128'h100, 1'b1, 1'b0);
        read_burst(25'hFFF, 5'd3, 128'h100, 128'h101, 128'h102, '0);
        read_burst(25'h000, 5'd2, 128'h101, 128'h102, '0, '0);
        // Upper address bits beyond MEM_AW are ignored.
        read_burst(25'h1001, 5'd1, 128'h102, '0, '0, '0);

        // size 0 is a single beat: the next write starts a fresh burst elsewhere.
        write_burst(25'h50, 5'd0, 16'hFFFF, 128'h55, 1'b0, 1'b0);
        write_burst(25'h60, 5'd1, 16'hFFFF, 128'h66, 1'b0, 1'b0);
        write_burst(25'h51, 5'd1, 16'hFFFF, 128'h77, 1'b0, 1'b0);
        read_burst(25'h50, 5'd2, 128'h55, 128'h77, '0, '0);
        read_burst(25'h60, 5'd1, 128'h66, '0, '0, '0);

        // Simultaneous read+write: write wins, read dropped, err sticky.
        chk("err_before_collision", 128'(err), 128'd0);
        write_burst(25'h40, 5'd1, 16'hFFFF, 128'hDEAD, 1'b0, 1'b1);
        repeat (READ_LAT + 3) @(negedge clk);
        chk("err_after_collision", 128'(err), 128'd1);
        chk("ready_after_collision", 128'(ready), 128'd1);
        read_burst(25'h40, 5'd1, 128'hDEAD, '0, '0, '0);
        chk("err_sticky", 128'(err), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
